ct_cp0_rst_inv_seq: RTL and testbench
=====================================

// Module: ct_cp0_rst_inv_seq
// PURPOSE
//  Reset-invalidate sequencer in CP0. Sits upstream of the IFU vector state machine.
//  On the IFU reset-invalidate request it sweeps every icache index through an
//  invalidate handshake and invalidates the BHT. It then returns a level done to the IFU.
//  On the IFU mrvbr request it captures the reset vector base from pad_cpu_rvba into
//  cp0_ifu_rvbr.
// PARAMETERS
//  INDEX_W   8    icache index width; the sweep covers 2**INDEX_W indices
// PORTS
//  forever_cpuclk          in   1        core clock (ungated source)
//  cpurst_b                in   1        asynchronous reset, active low
//  cp0_yy_clk_en           in   1        global clock-gate enable
//  cp0_ifu_icg_en          in   1        module clock-gate enable
//  pad_yy_icg_scan_en      in   1        scan clock-gate override
//  ifu_cp0_rst_inv_req     in   1        1-cycle pulse: start invalidate sweep
//  ifu_cp0_rst_mrvbr_req   in   1        1-cycle pulse: capture pad_cpu_rvba
//  pad_cpu_rvba            in   40       reset vector base from pad
//  icache_cp0_inv_ack      in   1        icache accepted the current index
//  bht_cp0_inv_done        in   1        1-cycle pulse: BHT invalidate complete
//  cp0_ifu_rst_inv_done    out  1        level: sweep complete
//  cp0_ifu_rvbr            out  40       reset vector base to IFU
//  cp0_icache_inv_vld      out  1        invalidate request valid
//  cp0_icache_inv_idx      out  INDEX_W  index being invalidated
//  cp0_bht_inv_req         out  1        level: BHT invalidate request
//  cp0_rst_inv_busy        out  1        debug: FSM not IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; FSM is IDLE; idx_cnt=0; bht_flag=0.
//  Clock gating: the state flops run on a gated_clk_cell clock.
//   - local enable = inv_req | mrvbr_req | bht_cp0_inv_done | (state!=IDLE).
//  FSM states: IDLE, SWEEP, WAIT_BHT.
//  - IDLE:
//     - inv_req -> SWEEP.
//     - Same edge: idx_cnt<=0, bht_flag<=0, done<=0.
//  - SWEEP:
//     - inv_vld=1 and inv_idx=idx_cnt.
//     - vld stays high back-to-back; on ack, idx_cnt+1 on the next cycle.
//     - ack while idx_cnt=2**INDEX_W-1: if bht_flag, or bht_cp0_inv_done in the same
//       cycle, -> IDLE with done<=1. Otherwise -> WAIT_BHT.
//     - The index counter never wraps during a sweep.
//  - WAIT_BHT: inv_vld=0. On bht_cp0_inv_done -> IDLE with done<=1.
//  - cp0_bht_inv_req: set on the edge after inv_req; cleared on the edge after
//    bht_cp0_inv_done. It is independent of the sweep progress.
//  - bht_flag: set by bht_cp0_inv_done while state!=IDLE; cleared by inv_req.
//  - done:
//     - Cleared on the edge after inv_req and set on completion.
//     - Holds 1 until the next inv_req.
//     - Because of this, the first RESET cycle of the IFU never sees a stale done.
//  - inv_req while in SWEEP or WAIT_BHT restarts the operation:
//     - state -> SWEEP, idx_cnt<=0, bht_flag<=0.
//     - bht_req stays 1; inv_req takes priority over ack in the same cycle.
//  - icache_cp0_inv_ack while inv_vld=0 is ignored.
//  - bht_cp0_inv_done in IDLE is ignored.
//  - rvbr:
//     - On mrvbr_req: cp0_ifu_rvbr <= {pad_cpu_rvba[39:2],2'b00}, visible next cycle.
//     - mrvbr_req and inv_req arrive in the same cycle; rvbr is stable long before done rises.
//  - Latency with ack every cycle (inv_req at cycle 0):
//     - vld in cycles 1..2**INDEX_W.
//     - done=1 from cycle 2**INDEX_W+1, provided the BHT finished earlier.
//  - cpurst_b low mid-sweep: everything returns immediately to the reset values.
// TESTING
//  1. Reset, then pulse inv_req+mrvbr_req with rvba=0x12_3456_789F; ack every cycle;
//     BHT done at cycle 10.
//     -> rvbr=0x12_3456_789C at cycle 1; idx 0..255 in cycles 1..256; done=1 at cycle 257.
//  2. Ack every 3rd cycle.
//     -> idx advances only after each ack; vld never drops; done 1 cycle after the 256th ack.
//  3. BHT done arrives 20 cycles after the last ack.
//     -> WAIT_BHT with vld=0; done rises on the cycle after bht_cp0_inv_done.
//  4. Second inv_req at idx=100.
//     -> done stays 0; idx restarts at 0; completion needs a fresh BHT done.
//  5. Last ack and BHT done in the same cycle.
//     -> goes direct to IDLE; done=1 next cycle; bht_req=0.
//  6. cpurst_b asserted at idx=50, then released.
//     -> all outputs 0, rvbr=0, done=0; idle until the next inv_req.

Source files
------------

// File: rtl/ct_cp0_rst_inv_seq.sv
// ct_cp0_rst_inv_seq: sweeps every icache index through an invalidate handshake and
// invalidates the BHT on the IFU reset-invalidate request; captures the reset vector base.
module ct_cp0_rst_inv_seq #(
  parameter int INDEX_W = 8
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               cp0_yy_clk_en,
  input  logic               cp0_ifu_icg_en,
  input  logic               pad_yy_icg_scan_en,
  input  logic               ifu_cp0_rst_inv_req,
  input  logic               ifu_cp0_rst_mrvbr_req,
  input  logic [39:0]        pad_cpu_rvba,
  input  logic               icache_cp0_inv_ack,
  input  logic               bht_cp0_inv_done,
  output logic               cp0_ifu_rst_inv_done,
  output logic [39:0]        cp0_ifu_rvbr,
  output logic               cp0_icache_inv_vld,
  output logic [INDEX_W-1:0] cp0_icache_inv_idx,
  output logic               cp0_bht_inv_req,
  output logic               cp0_rst_inv_busy
);
  typedef enum logic [1:0] {IDLE, SWEEP, WAIT_BHT} state_t;
  state_t             r_state, w_next;
  logic [INDEX_W-1:0] r_idx_cnt;
  logic               r_bht_flag, r_done, r_bht_req;
  logic [39:0]        r_rvbr;
  logic               w_local_en, w_clk_en, w_ack, w_last, w_cmplt, w_vld, w_busy;
  // Clock-enable form of the gated clock cell: flops only update when something can change.
  assign w_local_en = ifu_cp0_rst_inv_req | ifu_cp0_rst_mrvbr_req | bht_cp0_inv_done | (r_state != IDLE);
  assign w_clk_en   = (cp0_yy_clk_en & (cp0_ifu_icg_en | w_local_en)) | pad_yy_icg_scan_en;
  assign w_ack      = (r_state == SWEEP) & icache_cp0_inv_ack;
  assign w_last     = &r_idx_cnt;
  assign w_cmplt    = ~ifu_cp0_rst_inv_req & ((w_ack & w_last & (r_bht_flag | bht_cp0_inv_done)) |
                                              ((r_state == WAIT_BHT) & bht_cp0_inv_done));
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) r_state <= IDLE;
    else if (w_clk_en) r_state <= w_next;
  always_comb begin
    w_next = ifu_cp0_rst_inv_req ? SWEEP :
             (w_ack & w_last) ? ((r_bht_flag | bht_cp0_inv_done) ? IDLE : WAIT_BHT) :
             ((r_state == WAIT_BHT) & bht_cp0_inv_done) ? IDLE : r_state;
  end
  always_comb begin
    w_vld  = r_state == SWEEP;
    w_busy = r_state != IDLE;
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_idx_cnt  <= '0;
      r_bht_flag <= 1'b0;
      r_done     <= 1'b0;
      r_bht_req  <= 1'b0;
      r_rvbr     <= '0;
    end else if (w_clk_en) begin
      r_idx_cnt  <= ifu_cp0_rst_inv_req ? '0 : (w_ack & ~w_last) ? r_idx_cnt + 1'b1 : r_idx_cnt;
      r_bht_flag <= ifu_cp0_rst_inv_req ? 1'b0 : (bht_cp0_inv_done & w_busy) ? 1'b1 : r_bht_flag;
      r_done     <= ifu_cp0_rst_inv_req ? 1'b0 : w_cmplt ? 1'b1 : r_done;
      r_bht_req  <= ifu_cp0_rst_inv_req ? 1'b1 : bht_cp0_inv_done ? 1'b0 : r_bht_req;
      r_rvbr     <= ifu_cp0_rst_mrvbr_req ? {pad_cpu_rvba[39:2], 2'b00} : r_rvbr;
    end
  assign cp0_ifu_rst_inv_done = r_done;
  assign cp0_ifu_rvbr         = r_rvbr;
  assign cp0_icache_inv_vld   = w_vld;
  assign cp0_icache_inv_idx   = w_vld ? r_idx_cnt : '0;
  assign cp0_bht_inv_req      = r_bht_req;
  assign cp0_rst_inv_busy     = w_busy;
endmodule

// File: tb/tb_ct_cp0_rst_inv_seq.sv
// tb_ct_cp0_rst_inv_seq: directed scenarios with randomized ack/BHT timing, checked
// against an operation-level reference model (acks counted, BHT completion seen).
module tb_ct_cp0_rst_inv_seq;
  localparam int N = 256;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        inv_req = 1'b0, mrvbr_req = 1'b0, ack = 1'b0, bht_done = 1'b0;
  logic [39:0] rvba = '0;
  logic        done, vld, bht_req, busy;
  logic [39:0] rvbr;
  logic [7:0]  idx;
  int vectors = 0, miscompares = 0;
  bit          m_active, m_seen, m_done, m_bhtreq;
  int          m_pos;
  logic [39:0] m_rvbr;

  always #5 clk = ~clk;

  ct_cp0_rst_inv_seq #(.INDEX_W(8)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .cp0_yy_clk_en(1'b1), .cp0_ifu_icg_en(1'b0),
    .pad_yy_icg_scan_en(1'b0), .ifu_cp0_rst_inv_req(inv_req), .ifu_cp0_rst_mrvbr_req(mrvbr_req),
    .pad_cpu_rvba(rvba), .icache_cp0_inv_ack(ack), .bht_cp0_inv_done(bht_done),
    .cp0_ifu_rst_inv_done(done), .cp0_ifu_rvbr(rvbr), .cp0_icache_inv_vld(vld),
    .cp0_icache_inv_idx(idx), .cp0_bht_inv_req(bht_req), .cp0_rst_inv_busy(busy));

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_vld = m_active && m_pos < N;
    chk("vld", 40'(vld), 40'(exp_vld));
    if (exp_vld) chk("idx", 40'(idx), 40'(m_pos));
    chk("done", 40'(done), 40'(m_done));
    chk("bht_req", 40'(bht_req), 40'(m_bhtreq));
    chk("busy", 40'(busy), 40'(m_active));
    chk("rvbr", rvbr, m_rvbr);
  endtask

  task automatic model_reset();
    m_active = 0; m_seen = 0; m_done = 0; m_bhtreq = 0; m_pos = 0; m_rvbr = '0;
  endtask

  // One operation = N index acks plus one BHT completion, in any order.
  task automatic model_update(input logic inv, input logic mrv, input logic a, input logic bd,
                              input logic [39:0] base);
    if (mrv) m_rvbr = {base[39:2], 2'b00};
    if (inv) begin
      m_active = 1; m_pos = 0; m_seen = 0; m_done = 0; m_bhtreq = 1;
    end else begin
      if (bd) m_bhtreq = 0;
      if (m_active) begin
        if (a && m_pos < N) m_pos++;
        if (bd) m_seen = 1;
        if (m_pos == N && m_seen) begin m_active = 0; m_done = 1; end
      end
    end
  endtask

  task automatic step(input logic inv, input logic mrv, input logic a, input logic bd,
                      input logic [39:0] base);
    inv_req = inv; mrvbr_req = mrv; ack = a; bht_done = bd; rvba = base;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update(inv, mrv, a, bd, base);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 40'($urandom));
  endtask

  // ack_every: 0 = random ~70%, n = every nth cycle.
  // bht_mode: 0 = bht_at cycles after (re)start, 1 = bht_at cycles after last ack, 2 = with last ack.
  task automatic op(input int ack_every, input int bht_mode, input int bht_at,
                    input int restart_pos, input int reset_pos, input logic [39:0] base);
    int t = 0, cyc = 0, wait_cnt = 0;
    bit bht_sent = 0, restarted = 0;
    logic a, bd, inv;
    step(1'b1, 1'b1, 1'b0, 1'b0, base);
    while (m_active && cyc < 3000) begin
      cyc++; t++;
      if (m_pos == N) wait_cnt++;
      if (reset_pos >= 0 && m_pos == reset_pos) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk); #1 rst_n = 1'b1;
        idle(4);
        return;
      end
      a   = ack_every > 0 ? 1'(t % ack_every == 0) : 1'($urandom_range(0, 99) < 70);
      inv = restart_pos >= 0 && !restarted && m_pos == restart_pos;
      bd  = !bht_sent && !inv && (bht_mode == 0 ? t == bht_at :
                                  bht_mode == 1 ? (m_pos == N && wait_cnt == bht_at) :
                                  (a && m_pos == N - 1));
      if (bd) bht_sent = 1;
      if (inv) begin restarted = 1; bht_sent = 0; t = 0; wait_cnt = 0; end
      step(inv, inv, a, bd, base);
    end
    vectors++;
    assert (cyc < 3000) else begin
      miscompares++;
      $error("FAIL timeout: observed %0d cycles expected < 3000", cyc);
    end
    idle(3);
  endtask

  initial begin
    model_reset();
    #12 check_all();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    op(1, 0, 10, -1, -1, 40'h12_3456_789F);
    op(3, 0, 10, -1, -1, 40'($urandom));
    op(1, 1, 20, -1, -1, 40'($urandom));
    op(1, 0, 10, 100, -1, 40'($urandom));
    op(1, 2, 0, -1, -1, 40'($urandom));
    op(1, 0, 10, -1, 50, 40'($urandom));
    idle(5);
    for (int k = 0; k < 3; k++)
      op(0, 0, $urandom_range(1, 450), -1, -1, {8'($urandom), 32'($urandom)});
    op(0, 1, $urandom_range(1, 30), 40, -1, {8'($urandom), 32'($urandom)});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
